// File: rtl/calc_core.sv
// calc_core: switch-operand calculator datapath with debounced store/execute
// buttons, a small operand register file, a four-op ALU and a display mux.
module calc_core #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DB_CYCLES = 120000,
  localparam int unsigned SEL_W    = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   sw,
  input  logic [SEL_W-1:0]   sel,
  input  logic [1:0]         op,
  input  logic [1:0]         view,
  input  logic               btn_store,
  input  logic               btn_exec,
  output logic [WIDTH-1:0]   disp_value,
  output logic [WIDTH-1:0]   acc,
  output logic               carry,
  output logic               zero,
  output logic               result_valid
);

  localparam int unsigned CNT_W  = $clog2(DB_CYCLES);
  localparam int unsigned N_BTN  = 2;
  localparam int unsigned BTN_ST = 0;
  localparam int unsigned BTN_EX = 1;

  // Button path state, index 0 = store, index 1 = execute
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] evt;
  logic [CNT_W-1:0] db_cnt [N_BTN];

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign btn_raw  = {btn_exec, btn_store};
  assign rd_val   = regs[sel];
  assign sum_ext  = {1'b0, rd_val} + {1'b0, sw};
  assign diff_ext = {1'b0, rd_val} - {1'b0, sw};

  // Two-flop synchronisers for the asynchronous raw buttons
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Debouncers: stable state follows only after DB_CYCLES consecutive differing cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge detect of the debounced state into registered one-cycle events
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable_q <= '0;
      evt      <= '0;
    end else begin
      stable_q <= stable;
      evt      <= stable & ~stable_q;
    end
  end

  // ALU between the selected register and the live switches
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      2'b00: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      2'b01: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      2'b10: alu_res = rd_val & sw;
      default: alu_res = rd_val ^ sw;
    endcase
  end

  // Register file write on store; execute reads the pre-store value via NBA ordering
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (evt[BTN_ST]) begin
      regs[sel] <= sw;
    end
  end

  // Accumulator, flags and result pulse; all hold between executes
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc          <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= evt[BTN_EX];
      if (evt[BTN_EX]) begin
        acc   <= alu_res;
        carry <= alu_carry;
        zero  <= (alu_res == '0);
      end
    end
  end

  // Display source select
  always_comb begin
    disp_value = acc;
    case (view)
      2'b00:   disp_value = sw;
      2'b01:   disp_value = rd_val;
      default: disp_value = acc;
    endcase
  end

endmodule

// File: doc/calc_core.md
# calc_core

Parametrised calculator datapath for the switch/button/seven-segment board top level. It latches switch operands into a small register file, executes one of four ALU operations between a selected register and the live switch value, and drives a display value plus status flags. Both buttons pass through an internal synchroniser and debouncer, so each physical press produces exactly one command. It sits between the raw board inputs and the existing nibble-to-seven-segment and display-mux logic.

## Interface
- WIDTH, 8, operand/result width in bits (≥4, multiple of 4 so the display splits into nibbles)
- DEPTH, 4, number of stored-operand registers; power of two, ≥2; SEL_W = clog2(DEPTH) derived
- DB_CYCLES, 120000, CLK cycles a synchronised button must stay changed before the debounced state follows (≥2)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- sw  in  WIDTH  live switch operand
- sel  in  SEL_W  register select, used by store, execute and view
- op  in  2  ALU op: 00 add, 01 sub (reg − sw), 10 and, 11 xor
- view  in  2  display source: 00 sw, 01 reg[sel], 10/11 acc
- btn_store  in  1  raw, asynchronous, bouncy, active-high store button
- btn_exec  in  1  raw, asynchronous, bouncy, active-high execute button
- disp_value  out  WIDTH  combinational mux selected by view
- acc  out  WIDTH  last result
- carry  out  1  add: carry-out; sub: borrow (1 when reg < sw); and/xor: 0
- zero  out  1  1 when the last result == 0
- result_valid  out  1  one-cycle pulse after each execute

## Operation
- Each button path: 2-flop synchroniser → debouncer → rising-edge detector → registered one-cycle event (store_evt, exec_evt).
- Debouncer: counter clears whenever the synchronised input equals the stable state. Otherwise it increments each cycle. On the cycle the counter equals DB_CYCLES−1 while still differing, the stable state toggles and the counter clears.
- Only a 0→1 stable transition raises an event. Release produces no event. A held button produces one event.
- store_evt: reg[sel] ← sw.
- exec_evt: acc ← reg[sel] op sw (mod 2^WIDTH). carry and zero update per op. result_valid pulses.
- Store and execute in the same cycle: execute reads the old reg[sel] (read-before-write), and both updates take effect.
- sel, op and sw are sampled on the clock edge at which the event is high, not at press time.
- Flags and acc hold between executes. Store never alters acc or the flags.
- Reset (synchronous, any cycle, including mid-debounce) clears the following to 0: all registers, acc, carry, zero, result_valid, synchronisers, counters, stable states and events.
- A button still held after reset deasserts is debounced again and yields one event.

## Timing
- Edge N is the first CLK edge sampling raw=1, with raw held steady afterwards.
- Synchroniser output goes high after edge N+1.
- Stable state goes high at edge N+1+DB_CYCLES.
- Event is high during the cycle after edge N+2+DB_CYCLES.
- reg/acc/flags update at edge N+3+DB_CYCLES. result_valid is high for the following cycle only.
- Any raw pulse whose synchronised high time is shorter than DB_CYCLES cycles produces no event.
- disp_value has zero latency from view, sel, sw, reg and acc.
- All outputs read 0 in the cycle after the reset edge.

## Test plan
Bench parameters: WIDTH=8, DEPTH=4, DB_CYCLES=4.
- Reset, then sw=0x25, sel=1, clean store press -> reg1=0x25 at edge N+7. With view=01, disp_value=0x25. acc=0x00, zero=0, result_valid never pulses.
- reg1=0x25, sw=0xE0, op=00, execute -> acc=0x05, carry=1, zero=0, one-cycle result_valid. Then sw=0x25, op=01 -> acc=0x00, carry=0, zero=1.
- reg1=0x10, sw=0x20, op=01 -> acc=0xF0, carry=1. Then op=10, sw=0x30 -> acc=0x10, carry=0. Then op=11, sw=0x10 -> acc=0x00, zero=1.
- btn_exec bounces 1,0,1,0 with 2-cycle phases, then held high for 20 cycles -> exactly one result_valid pulse. A 3-cycle glitch alone gives none. Release gives none.
- Both buttons pressed on the same edge, reg2=0x03, sw=0x05, op=00, sel=2 -> acc=0x08 and reg2=0x05 on the same edge.
- RST asserted 2 cycles into a debounce with the button held -> no event during reset. After reset deasserts, exactly one event at the full latency from the first post-reset edge. All outputs read 0 right after the reset edge.
